// File: rtl/hex_display_arbiter_pkg.sv
// Shared constants for the hex display arbiter: requester count, dwell defaults,
// counter width and FSM state encodings.
package hex_display_arbiter_pkg;

    localparam int NREQ_C        = 4;
    localparam int DWELL_DEFAULT = 16;
    localparam int CNT_W         = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

endpackage

// File: rtl/hex_display_arbiter_rr_picker.sv
// Round-robin 4-way priority encoder: search starts one past the last winner.
// Purely combinational; zero latency, no backpressure.
module rr_picker (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] winner,
    output logic       any
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = last;
        for (int i = 1; i <= 4; i++) begin
            // 2-bit add wraps naturally, so i=4 revisits the last winner itself
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/hex_display_arbiter.sv
// Shares one 8-bit HEX display among four requesters, each winner shown for DWELL cycles.
// Latency: capture on the edge after req; freeze stalls the dwell, requests wait at level.
module hex_display_arbiter
    import hex_display_arbiter_pkg::*;
#(
    parameter int DWELL = DWELL_DEFAULT,
    parameter int NREQ  = NREQ_C
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [7:0]      val0,
    input  logic [7:0]      val1,
    input  logic [7:0]      val2,
    input  logic [7:0]      val3,
    input  logic            freeze,
    output logic [NREQ-1:0] gnt,
    output logic [7:0]      data,
    output logic [1:0]      src,
    output logic            active
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       last;
    logic [1:0]       win;
    logic             any;
    logic [7:0]       win_val;
    logic             capture;

    rr_picker u_picker (
        .req    (req),
        .last   (last),
        .winner (win),
        .any    (any)
    );

    always_comb begin
        win_val = val0;
        case (win)
            2'd0: win_val = val0;
            2'd1: win_val = val1;
            2'd2: win_val = val2;
            2'd3: win_val = val3;
            default: win_val = val0;
        endcase
    end

    // back-to-back capture at the end of a dwell leaves no idle gap
    always_comb begin
        capture = 1'b0;
        if (state == ST_IDLE)
            capture = any;
        else
            capture = !freeze && (cnt == '0) && any;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            data   <= '0;
            src    <= '0;
            gnt    <= '0;
            active <= 1'b0;
            last   <= 2'd3;
        end else begin
            gnt <= '0;
            if (capture) begin
                state     <= ST_SHOW;
                cnt       <= RELOAD;
                data      <= win_val;
                src       <= win;
                last      <= win;
                gnt[win]  <= 1'b1;
                active    <= 1'b1;
            end else if (state == ST_SHOW && !freeze) begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    state  <= ST_IDLE;
                    active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench: stimulus queues expected grants, negedge monitors pop and compare.
module tb_hex_display_arbiter;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] data;
        logic [1:0] src;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_a, req_b;
    logic [7:0] va0, va1, va2, va3, vb0, vb1, vb2, vb3;
    logic       freeze_a, freeze_b;
    logic [3:0] gnt_a, gnt_b;
    logic [7:0] data_a, data_b;
    logic [1:0] src_a, src_b;
    logic       active_a, active_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hex_display_arbiter #(.DWELL(4), .NREQ(4)) u_dut_a (
        .clk(clk), .rst(rst), .req(req_a),
        .val0(va0), .val1(va1), .val2(va2), .val3(va3),
        .freeze(freeze_a), .gnt(gnt_a), .data(data_a), .src(src_a), .active(active_a)
    );

    hex_display_arbiter #(.DWELL(2), .NREQ(4)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b),
        .val0(vb0), .val1(vb1), .val2(vb2), .val3(vb3),
        .freeze(freeze_b), .gnt(gnt_b), .data(data_b), .src(src_b), .active(active_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [3:0] g, input logic [7:0] d, input logic [1:0] s, input int c);
        qa.push_back('{gnt: g, data: d, src: s, cyc: c});
    endtask

    task automatic push_b(input logic [3:0] g, input logic [7:0] d, input logic [1:0] s, input int c);
        qb.push_back('{gnt: g, data: d, src: s, cyc: c});
    endtask

    always @(negedge clk) begin
        if (gnt_a !== 4'b0000) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_gnt_a: got gnt=%b at cycle %0d, required none", gnt_a, cyc);
            end else begin
                ea = qa.pop_front();
                chk("gnt_a", 32'(gnt_a), 32'(ea.gnt));
                chk("data_a", 32'(data_a), 32'(ea.data));
                chk("src_a", 32'(src_a), 32'(ea.src));
                chk("gnt_cycle_a", cyc, ea.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (gnt_b !== 4'b0000) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_gnt_b: got gnt=%b at cycle %0d, required none", gnt_b, cyc);
            end else begin
                eb = qb.pop_front();
                chk("gnt_b", 32'(gnt_b), 32'(eb.gnt));
                chk("data_b", 32'(data_b), 32'(eb.data));
                chk("src_b", 32'(src_b), 32'(eb.src));
                chk("gnt_cycle_b", cyc, eb.cyc);
            end
        end
    end

    initial begin
        int k;
        int n;
        rst = 1'b1;
        req_a = '0; req_b = '0;
        va0 = '0; va1 = '0; va2 = '0; va3 = '0;
        vb0 = '0; vb1 = '0; vb2 = '0; vb3 = '0;
        freeze_a = 1'b0; freeze_b = 1'b0;
        tick(2);
        chk("rst_gnt", 32'(gnt_a), 0);
        chk("rst_data", 32'(data_a), 0);
        chk("rst_src", 32'(src_a), 0);
        chk("rst_active", 32'(active_a), 0);
        chk("rst_active_b", 32'(active_b), 0);
        rst = 1'b0;
        tick(1);

        // single request, dwell length, idle hold
        k = cyc;
        req_a = 4'b0001; va0 = 8'd123;
        push_a(4'b0001, 8'd123, 2'd0, k + 1);
        tick(1);
        req_a = 4'b0000;
        n = active_a ? 1 : 0;
        repeat (5) begin
            tick(1);
            if (active_a) n++;
        end
        chk("active_len", n, 4);
        chk("idle_data", 32'(data_a), 123);
        chk("idle_src", 32'(src_a), 0);
        chk("idle_active", 32'(active_a), 0);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;

        // full round robin, then wrap-around from 2 to 0 with fresh value
        k = cyc;
        req_a = 4'b1111; va0 = 8'd10; va1 = 8'd20; va2 = 8'd30; va3 = 8'd40;
        push_a(4'b0001, 8'd10, 2'd0, k + 1);
        push_a(4'b0010, 8'd20, 2'd1, k + 5);
        push_a(4'b0100, 8'd30, 2'd2, k + 9);
        push_a(4'b1000, 8'd40, 2'd3, k + 13);
        push_a(4'b0001, 8'd10, 2'd0, k + 17);
        push_a(4'b0100, 8'd30, 2'd2, k + 21);
        push_a(4'b0001, 8'd11, 2'd0, k + 25);
        tick(17);
        req_a = 4'b0100;
        tick(4);
        req_a = 4'b0101; va0 = 8'd11;
        tick(4);
        req_a = 4'b0000;
        tick(6);

        // freeze for 5 cycles stretches the dwell; mid-dwell request waits
        k = cyc;
        req_a = 4'b0010; va1 = 8'd77;
        push_a(4'b0010, 8'd77, 2'd1, k + 1);
        push_a(4'b0100, 8'd99, 2'd2, k + 10);
        tick(1);
        req_a = 4'b0100; va2 = 8'd99;
        tick(1);
        freeze_a = 1'b1;
        tick(5);
        chk("active_frozen", 32'(active_a), 1);
        freeze_a = 1'b0;
        tick(2);
        chk("dwell9_src", 32'(src_a), 1);
        chk("dwell9_data", 32'(data_a), 77);
        chk("dwell9_active", 32'(active_a), 1);
        tick(1);
        req_a = 4'b0000;
        tick(6);

        // reset mid-show overrides freeze and dwell, held request served right after
        k = cyc;
        req_a = 4'b1000; va3 = 8'd200;
        push_a(4'b1000, 8'd200, 2'd3, k + 1);
        tick(2);
        rst = 1'b1; freeze_a = 1'b1;
        tick(1);
        chk("midrst_data", 32'(data_a), 0);
        chk("midrst_src", 32'(src_a), 0);
        chk("midrst_active", 32'(active_a), 0);
        chk("midrst_gnt", 32'(gnt_a), 0);
        rst = 1'b0; freeze_a = 1'b0; va3 = 8'd201;
        push_a(4'b1000, 8'd201, 2'd3, cyc + 1);
        tick(1);
        req_a = 4'b0000;
        tick(6);

        // DWELL=2 alternation, 255 passthrough, req[1] dropped before its turn
        k = cyc;
        req_b = 4'b0011; vb0 = 8'd5; vb1 = 8'd255;
        push_b(4'b0001, 8'd5, 2'd0, k + 1);
        push_b(4'b0010, 8'd255, 2'd1, k + 3);
        push_b(4'b0001, 8'd5, 2'd0, k + 5);
        push_b(4'b0010, 8'd255, 2'd1, k + 7);
        push_b(4'b0001, 8'd5, 2'd0, k + 9);
        tick(10);
        req_b = 4'b0001;
        push_b(4'b0001, 8'd5, 2'd0, k + 11);
        tick(1);
        req_b = 4'b0000;
        tick(4);
        chk("b_idle_active", 32'(active_b), 0);
        chk("b_idle_data", 32'(data_b), 5);
        chk("b_idle_src", 32'(src_b), 0);

        tick(2);
        chk("pending_a", qa.size(), 0);
        chk("pending_b", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_display_arbiter.md
HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

Interface
REQ-001 Parameter DWELL, default 16, is the number of cycles each granted value is shown; legal range is 2..65535.
REQ-002 Parameter NREQ, default 4, is the number of requesters; it is fixed at 4 in this revision.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  is the synchronous, active-high reset.
REQ-005 req  input  4  carries per-requester display requests; req[i] is level-sensitive and held until granted.
REQ-006 val0..val3  input  8 each  carry the unsigned value offered by requester i.
REQ-007 freeze  input  1  pauses the dwell countdown while high, for operator pause.
REQ-008 gnt  output  4  is a one-hot, one-cycle pulse marking the cycle in which val[i] was captured.
REQ-009 data  output  8  is the captured value that drives the 3-digit decimal HEX display.
REQ-010 src  output  2  is the index of the requester currently shown.
REQ-011 active  output  1  is high while a granted value is within its dwell window.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and SHOW.
REQ-013 In IDLE with req != 0, the next edge SHALL select winner w, capture val_w into data, load src=w, pulse gnt[w], load cnt=DWELL-1, set active=1, and enter SHOW.
REQ-014 Latency: req asserted before edge N SHALL produce gnt/data/src valid after edge N, with no combinational path from req to outputs.
REQ-015 In SHOW, cnt SHALL decrement by 1 per cycle while freeze=0 and SHALL hold its value while freeze=1.
REQ-016 In SHOW with cnt=0 and freeze=0, a pending req SHALL cause the next winner to be captured on the same edge, with no gap cycle, and cnt reloaded to DWELL-1.
REQ-017 In SHOW with cnt=0, freeze=0 and req=0, the block SHALL enter IDLE with active=0, while data and src hold their last values.
REQ-018 Winner selection SHALL be round-robin: search starts at (last granted index + 1) mod 4 and the first asserted req wins.
REQ-019 A requester still requesting when its turn recurs SHALL be re-granted and its fresh value captured.
REQ-020 Requests arriving mid-dwell SHALL NOT preempt the dwell and SHALL be served only at the cnt=0 boundary.
REQ-021 A request dropped before its grant SHALL be ignored, with no latching of pending requests.
REQ-022 gnt SHALL be zero in every cycle except capture cycles, and never has more than one bit set.
REQ-023 data SHALL be passed through unmodified, over the full range 0..255.

Reset
REQ-024 While rst=1 at an edge: state=IDLE, cnt=0, data=0, src=0, gnt=0, active=0, and the last-granted pointer=3, so req[0] has first priority.
REQ-025 rst SHALL override freeze and any in-progress dwell, and an asserted req SHALL be served on the first edge after rst deasserts.

Structure
REQ-026 A shared package SHALL hold the state enumeration, NREQ=4, the default DWELL, and the counter width (16).
REQ-027 One sub-module, rr_picker, SHALL provide the combinational 4-way round-robin priority encoder (inputs req and last; outputs winner index and any).
REQ-028 The top SHALL contain the FSM, the dwell counter, the capture registers and the last-granted pointer.

Verification (DWELL=4 unless stated)
REQ-029 Reset then req=0001 with val0=123 -> one cycle later gnt=0001, data=123, src=0, active=1; active stays high exactly 4 cycles, then IDLE with data=123.
REQ-030 req=1111 held, vals 10/20/30/40 -> grants in order 0,1,2,3,0 every 4 cycles with no gap, and data follows 10,20,30,40,10.
REQ-031 After granting 2, req=0101 -> next grant is 0 (wrap-around), not 2.
REQ-032 freeze=1 for 5 cycles mid-dwell -> active lasts 9 cycles total, and the next gnt is delayed by 5.
REQ-033 rst pulsed mid-SHOW with req=1000 held -> outputs zeroed, then gnt=1000 on the first edge after reset.
REQ-034 Boundaries: DWELL=2 with req=0011 alternates every 2 cycles; val=255 -> data=255; req[1] dropped before its turn -> never granted.
